// File: rtl/conv_layer_sequencer_pkg.sv
// Shared definitions for the convolution layer sequencer: FSM state
// encoding, Sign select codes and command type constants.
package conv_layer_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PA_SET  = 3'd1,
        PA_GO   = 3'd2,
        PA_WAIT = 3'd3,
        CU_SET  = 3'd4,
        CU_GO   = 3'd5,
        CU_WAIT = 3'd6,
        DONE    = 3'd7
    } seq_state_t;

    localparam logic [3:0] SIGN_NONE = 4'b0000;
    localparam logic [3:0] SIGN_PARA = 4'b0001;
    localparam logic [3:0] SIGN_CU   = 4'b0010;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_PARA = 2'b01;
    localparam logic [1:0] CMD_CU   = 2'b10;
    localparam logic [1:0] CMD_BOTH = 2'b11;

    // Command wants a parameter load phase.
    function automatic logic cmd_has_para(input logic [1:0] cmd_type);
        return (cmd_type & CMD_PARA) != 2'b00;
    endfunction

    // Command wants a compute phase.
    function automatic logic cmd_has_cu(input logic [1:0] cmd_type);
        return (cmd_type & CMD_CU) != 2'b00;
    endfunction

endpackage

// File: rtl/conv_layer_sequencer.sv
// Per-layer controller for the 3x3/1x1 convolution compute block.
// Captures one host command, programs the instruction registers, pulses
// Start_Pa / Start_Cu, waits for the completion pulses and re-arms the
// sub-blocks with Next_Reg. All outputs are registered.
// Optional build macro: SEQ_WATCHDOG_EN adds a wait-state watchdog that
// abandons a stuck layer and raises the sticky Err flag.
module conv_layer_sequencer
    import conv_layer_sequencer_pkg::*;
#(
    parameter int CMD_TYPE_W  = 2,
    parameter int LAYER_CNT_W = 16,
    parameter int WDOG_W      = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Cmd_Valid,
    output logic                   Cmd_Ready,
    input  logic [CMD_TYPE_W-1:0]  Cmd_Type,
    input  logic [63:0]            Cmd_Para,
    input  logic [127:0]           Cmd_Cu,
    output logic [3:0]             Sign,
    output logic [31:0]            Reg_4,
    output logic [31:0]            Reg_5,
    output logic [31:0]            Reg_6,
    output logic [31:0]            Reg_7,
    output logic                   Start_Pa,
    output logic                   Start_Cu,
    output logic                   Next_Reg,
    input  logic                   Write_Block_Complete,
    input  logic                   Conv_Complete,
    input  logic                   Stride_Complete,
    output logic                   Busy,
    output logic                   Layer_Done,
    output logic [LAYER_CNT_W-1:0] Layer_Count,
    output logic                   Err
);

    seq_state_t             state_r;
    logic                   phase_r;
    logic                   cu_pending_r;
    logic                   conv_seen_r;
    logic                   stride_seen_r;
    logic [127:0]           cmd_cu_r;
    logic [3:0]             sign_r;
    logic [31:0]            reg_4_r;
    logic [31:0]            reg_5_r;
    logic [31:0]            reg_6_r;
    logic [31:0]            reg_7_r;
    logic                   start_pa_r;
    logic                   start_cu_r;
    logic                   next_reg_r;
    logic                   layer_done_r;
    logic                   busy_r;
    logic                   ready_r;
    logic [LAYER_CNT_W-1:0] layer_count_r;

    logic                   cu_both_s;
    logic                   wait_ok_s;
    logic                   wdog_timeout_s;

    // A completion pulse in the same cycle counts as if already latched.
    assign cu_both_s = (conv_seen_r | Conv_Complete) & (stride_seen_r | Stride_Complete);
    assign wait_ok_s = ((state_r == PA_WAIT) & Write_Block_Complete) |
                       ((state_r == CU_WAIT) & cu_both_s);

`ifdef SEQ_WATCHDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

    logic [WDOG_W-1:0] wdog_r;
    logic              err_r;
    logic              in_wait_s;

    assign in_wait_s      = (state_r == PA_WAIT) | (state_r == CU_WAIT);
    // Expire on the edge where the counter would reach all-ones; a real
    // completion in that same cycle still wins.
    assign wdog_timeout_s = in_wait_s & (wdog_r == WDOG_LAST) & ~wait_ok_s;

    // Wait-state watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_r <= '0;
            err_r  <= 1'b0;
        end else begin
            if (in_wait_s) begin
                wdog_r <= wdog_r + {{(WDOG_W-1){1'b0}}, 1'b1};
            end else begin
                wdog_r <= '0;
            end
            if (wdog_timeout_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign Err = err_r;
`else
    // Without the watchdog the wait states never time out; the width
    // parameter is kept so both builds share one interface.
    assign wdog_timeout_s = |{WDOG_W{1'b0}};
    assign Err            = 1'b0;
`endif

    // Main sequencing FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            phase_r       <= 1'b0;
            cu_pending_r  <= 1'b0;
            conv_seen_r   <= 1'b0;
            stride_seen_r <= 1'b0;
            cmd_cu_r      <= 128'd0;
            sign_r        <= SIGN_NONE;
            reg_4_r       <= 32'd0;
            reg_5_r       <= 32'd0;
            reg_6_r       <= 32'd0;
            reg_7_r       <= 32'd0;
            start_pa_r    <= 1'b0;
            start_cu_r    <= 1'b0;
            next_reg_r    <= 1'b0;
            layer_done_r  <= 1'b0;
            busy_r        <= 1'b0;
            ready_r       <= 1'b1;
            layer_count_r <= '0;
        end else begin
            start_pa_r   <= 1'b0;
            start_cu_r   <= 1'b0;
            next_reg_r   <= 1'b0;
            layer_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (Cmd_Valid && ready_r) begin
                        ready_r      <= 1'b0;
                        busy_r       <= 1'b1;
                        cmd_cu_r     <= Cmd_Cu;
                        cu_pending_r <= cmd_has_cu(Cmd_Type[1:0]);
                        phase_r      <= 1'b0;
                        sign_r       <= SIGN_NONE;
                        if (cmd_has_para(Cmd_Type[1:0])) begin
                            state_r <= PA_SET;
                            reg_4_r <= Cmd_Para[63:32];
                            reg_5_r <= Cmd_Para[31:0];
                            reg_6_r <= 32'd0;
                            reg_7_r <= 32'd0;
                        end else if (cmd_has_cu(Cmd_Type[1:0])) begin
                            state_r <= CU_SET;
                            reg_4_r <= Cmd_Cu[31:0];
                            reg_5_r <= Cmd_Cu[63:32];
                            reg_6_r <= Cmd_Cu[95:64];
                            reg_7_r <= Cmd_Cu[127:96];
                        end else begin
                            state_r      <= DONE;
                            next_reg_r   <= 1'b1;
                            layer_done_r <= 1'b1;
                        end
                    end
                end
                PA_SET: begin
                    if (!phase_r) begin
                        sign_r  <= SIGN_PARA;
                        phase_r <= 1'b1;
                    end else begin
                        sign_r     <= SIGN_NONE;
                        phase_r    <= 1'b0;
                        start_pa_r <= 1'b1;
                        state_r    <= PA_GO;
                    end
                end
                PA_GO: begin
                    state_r <= PA_WAIT;
                end
                PA_WAIT: begin
                    if (Write_Block_Complete) begin
                        if (cu_pending_r) begin
                            state_r <= CU_SET;
                            reg_4_r <= cmd_cu_r[31:0];
                            reg_5_r <= cmd_cu_r[63:32];
                            reg_6_r <= cmd_cu_r[95:64];
                            reg_7_r <= cmd_cu_r[127:96];
                        end else begin
                            state_r      <= DONE;
                            next_reg_r   <= 1'b1;
                            layer_done_r <= 1'b1;
                        end
                    end else if (wdog_timeout_s) begin
                        state_r      <= DONE;
                        next_reg_r   <= 1'b1;
                        layer_done_r <= 1'b1;
                    end
                end
                CU_SET: begin
                    if (!phase_r) begin
                        sign_r  <= SIGN_CU;
                        phase_r <= 1'b1;
                    end else begin
                        sign_r     <= SIGN_NONE;
                        phase_r    <= 1'b0;
                        start_cu_r <= 1'b1;
                        state_r    <= CU_GO;
                    end
                end
                CU_GO: begin
                    conv_seen_r   <= 1'b0;
                    stride_seen_r <= 1'b0;
                    state_r       <= CU_WAIT;
                end
                CU_WAIT: begin
                    if (cu_both_s) begin
                        state_r       <= DONE;
                        next_reg_r    <= 1'b1;
                        layer_done_r  <= 1'b1;
                        layer_count_r <= layer_count_r + {{(LAYER_CNT_W-1){1'b0}}, 1'b1};
                    end else if (wdog_timeout_s) begin
                        state_r      <= DONE;
                        next_reg_r   <= 1'b1;
                        layer_done_r <= 1'b1;
                    end else begin
                        conv_seen_r   <= conv_seen_r | Conv_Complete;
                        stride_seen_r <= stride_seen_r | Stride_Complete;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign Cmd_Ready   = ready_r;
    assign Sign        = sign_r;
    assign Reg_4       = reg_4_r;
    assign Reg_5       = reg_5_r;
    assign Reg_6       = reg_6_r;
    assign Reg_7       = reg_7_r;
    assign Start_Pa    = start_pa_r;
    assign Start_Cu    = start_cu_r;
    assign Next_Reg    = next_reg_r;
    assign Busy        = busy_r;
    assign Layer_Done  = layer_done_r;
    assign Layer_Count = layer_count_r;

endmodule
